// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register file sequencer: opcodes, instruction
// layout and state encoding.
package regfile_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    localparam logic [7:0] HALT_INSTR = 8'hFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [7:0] raw);
        instr_t d;
        d.op  = raw[OP_HI:OP_LO];
        d.rd  = raw[RD_HI:RD_LO];
        d.rs1 = raw[RS1_HI:RS1_LO];
        d.rs2 = raw[RS2_HI:RS2_LO];
        return d;
    endfunction

endpackage

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU used in the EXEC step of the sequencer.
// Carry is the ADD carry-out or the SUB borrow; logic ops clear it.
module seq_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND: res = a & b;
            OP_MOV: res = a;
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer: accepts an instruction, reads two registers, runs the
// ALU and writes the result back with a one-cycle strobe.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [7:0]        instr_data,
    output logic              instr_ready,
    output logic [1:0]        rf_read_reg1,
    output logic [1:0]        rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_reg_write,
    output logic [1:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy,
    output logic              halted,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic [CNT_W-1:0]  retired
);

    logic [2:0]        state;
    instr_t            ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_zero;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (ir.op),
        .a     (op_a),
        .b     (op_b),
        .res   (alu_res),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    assign instr_ready   = (state == ST_IDLE) && !rst;
    assign busy          = (state == ST_READ) || (state == ST_EXEC) || (state == ST_WB);
    assign rf_read_reg1  = ir.rs1;
    assign rf_read_reg2  = ir.rs2;
    assign rf_reg_write  = (state == ST_WB);
    assign rf_write_reg  = ir.rd;
    assign rf_write_data = result;

    // Operands are captured in READ, so a destination that aliases a source
    // is safe: the writeback happens two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            retired    <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir <= decode_instr(instr_data);
                        if (instr_data == HALT_INSTR) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    op_a  <= rf_read_data1;
                    op_b  <= rf_read_data2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result     <= alu_res;
                    flag_zero  <= alu_zero;
                    flag_carry <= alu_carry;
                    state      <= ST_WB;
                end
                ST_WB: begin
                    retired <= retired + CNT_W'(1);
                    state   <= ST_IDLE;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a 4x8 register file, an instruction-level
// model compared every cycle, and directed sequences with literal results.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic       instr_ready;
    logic [1:0] rf_read_reg1, rf_read_reg2;
    logic [7:0] rf_read_data1, rf_read_data2;
    logic       rf_reg_write;
    logic [1:0] rf_write_reg;
    logic [7:0] rf_write_data;
    logic       busy, halted, flag_zero, flag_carry;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_W(8), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .busy          (busy),
        .halted        (halted),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .retired       (retired)
    );

    // Register file seen by the DUT; reset has priority over a write.
    logic [7:0] rf [4];
    logic [7:0] pv [4];
    logic       preload_req = 1'b0;
    int         write_count = 0;

    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 4; i++) rf[i] <= pv[i];
        end else if (!rst && rf_reg_write) begin
            rf[rf_write_reg] <= rf_write_data;
            write_count      <= write_count + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: an accepted instruction completes three edges
    // after acceptance; m_age counts edges since acceptance.
    logic [7:0] m_regs [4];
    int         m_age = 0;
    bit         m_live = 0;
    bit         m_halted = 0;
    bit         m_zero = 0, m_carry = 0;
    logic [7:0] m_retired = 0;
    logic [7:0] m_res;
    bit         m_car;
    logic [1:0] m_rd, m_rs1, m_rs2;

    function automatic logic [8:0] modelOp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia = a, ib = b;
        case (op)
            2'd0: return 9'((ia + ib) % 512);
            2'd1: return {ia < ib, 8'((ia - ib + 256) % 256)};
            2'd2: return {1'b0, a & b};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [8:0] r;
        if (preload_req) begin
            for (int i = 0; i < 4; i++) m_regs[i] = pv[i];
        end
        if (rst) begin
            m_live = 1; m_age = 0; m_halted = 0;
            m_zero = 0; m_carry = 0; m_retired = 0;
        end else if (m_live) begin
            if (m_age == 0) begin
                if (!m_halted && instr_valid) begin
                    if (instr_data == 8'hFF) begin
                        m_halted = 1;
                    end else begin
                        m_rd  = instr_data[5:4];
                        m_rs1 = instr_data[3:2];
                        m_rs2 = instr_data[1:0];
                        r     = modelOp(instr_data[7:6], m_regs[m_rs1], m_regs[m_rs2]);
                        m_res = r[7:0];
                        m_car = r[8];
                        m_age = 1;
                    end
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                m_zero  = (m_res == 8'h00);
                m_carry = m_car;
                m_age   = 3;
            end else begin
                m_regs[m_rd] = m_res;
                m_retired    = m_retired + 8'd1;
                m_age        = 0;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("instr_ready", instr_ready, (m_age == 0 && !m_halted && !rst));
            checkOutput("busy", busy, (m_age != 0));
            checkOutput("halted", halted, m_halted);
            checkOutput("flag_zero", flag_zero, m_zero);
            checkOutput("flag_carry", flag_carry, m_carry);
            checkOutput("retired", retired, m_retired);
            checkOutput("rf_reg_write", rf_reg_write, (m_age == 3));
            if (m_age == 1) begin
                checkOutput("rf_read_reg1", rf_read_reg1, m_rs1);
                checkOutput("rf_read_reg2", rf_read_reg2, m_rs2);
            end
            if (m_age == 3) begin
                checkOutput("rf_write_reg", rf_write_reg, m_rd);
                checkOutput("rf_write_data", rf_write_data, m_res);
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
        @(negedge clk);
        pv[0] = v0; pv[1] = v1; pv[2] = v2; pv[3] = v3;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    // Present one instruction at the next ready cycle; returns at the negedge
    // after the handshake edge.
    task automatic applyStimulus(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!instr_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) checkOutput("ready_timeout", 0, 1);
        instr_valid = 1'b1;
        instr_data  = d;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic waitDone();
        int t = 0;
        while (!instr_ready && !halted && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int wc;

        doReset();
        @(negedge clk);
        checkOutput("reset_ready", instr_ready, 1);
        checkOutput("reset_retired", retired, 0);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_write", rf_reg_write, 0);

        // ADD r0 <- r1 + r2, plus handshake-to-next-ready latency
        preload(8'd5, 8'd10, 8'd20, 8'd30);
        wc = write_count;
        applyStimulus(8'h06);
        cnt = 0;
        while (!instr_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("add_latency", cnt, 3);
        checkOutput("add_r0", rf[0], 8'd30);
        checkOutput("add_zero", flag_zero, 0);
        checkOutput("add_carry", flag_carry, 0);
        checkOutput("add_retired", retired, 1);
        checkOutput("add_writes", write_count - wc, 1);

        // SUB / AND / MOV / ADD-overflow chain
        doReset();
        preload(8'd5, 8'd10, 8'd20, 8'd30);
        applyStimulus(8'h71); waitDone();
        checkOutput("sub_r3", rf[3], 8'hFB);
        checkOutput("sub_carry", flag_carry, 1);
        checkOutput("sub_zero", flag_zero, 0);
        applyStimulus(8'h55); waitDone();
        checkOutput("sub_self_r1", rf[1], 8'h00);
        checkOutput("sub_self_zero", flag_zero, 1);
        checkOutput("sub_self_carry", flag_carry, 0);
        applyStimulus(8'hA6); waitDone();
        checkOutput("and_r2", rf[2], 8'h00);
        checkOutput("and_zero", flag_zero, 1);
        applyStimulus(8'hCC); waitDone();
        checkOutput("mov_r0", rf[0], 8'hFB);
        checkOutput("mov_carry", flag_carry, 0);
        applyStimulus(8'h00); waitDone();
        checkOutput("add_ovf_r0", rf[0], 8'hF6);
        checkOutput("add_ovf_carry", flag_carry, 1);
        checkOutput("chain_retired", retired, 5);

        // instr_valid held high with changing data while busy
        doReset();
        preload(8'd5, 8'd10, 8'd20, 8'd30);
        wc = write_count;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 8'h06;
        @(negedge clk); instr_data = 8'h71;
        @(negedge clk); instr_data = 8'h55;
        @(negedge clk); instr_data = 8'hA6;
        @(negedge clk); instr_valid = 1'b0;
        waitDone();
        checkOutput("bp_writes", write_count - wc, 1);
        checkOutput("bp_r0", rf[0], 8'd30);
        checkOutput("bp_r3", rf[3], 8'd30);

        // HALT is sticky and writes nothing
        applyStimulus(8'hFF);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_ready", instr_ready, 0);
        wc = write_count;
        instr_valid = 1'b1;
        instr_data  = 8'h06;
        repeat (20) @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("halt_writes", write_count - wc, 0);
        checkOutput("halt_still", halted, 1);
        doReset();
        @(negedge clk);
        checkOutput("unhalt_halted", halted, 0);
        checkOutput("unhalt_ready", instr_ready, 1);

        // Reset during EXEC abandons the instruction
        preload(8'd5, 8'd10, 8'd20, 8'd30);
        wc = write_count;
        applyStimulus(8'h06);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_exec_writes", write_count - wc, 0);
        checkOutput("rst_exec_retired", retired, 0);
        checkOutput("rst_exec_ready", instr_ready, 1);
        checkOutput("rst_exec_r0", rf[0], 8'd5);

        // retired wraps after 256 writebacks
        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'hC0);
            waitDone();
            if (i == 254) checkOutput("retired_255", retired, 8'd255);
        end
        checkOutput("retired_wrap", retired, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
